s3g_rx: RTL and testbench
=========================

# s3g_rx

Receives the S3G-style byte framing used on the host link and recovers packets from it. Frame: start byte 0xD5, length byte, 0–15 payload bytes, CRC-8 byte. The block sits between a UART receiver byte strobe and the command decoder. Its output is a 16-byte parallel payload image plus a length, published atomically only when a frame passes the CRC check. It is the receive counterpart of the packet transmitter on the same link and uses the identical CRC.

## Interface
- `TIMEOUT_CYCLES`, default 100000: maximum idle clocks between bytes inside a frame before the frame is aborted.
- `MAX_LEN`, default 15: largest accepted payload length. The payload buffer is 16 bytes, so `MAX_LEN` must be ≤15.
- `clk` input, 1 bit: the single clock.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `rx_data` input, 8 bits: received byte. Valid only when `rx_valid` is high.
- `rx_valid` input, 1 bit: one-cycle strobe, one per received byte.
- `packet_valid` output, 1 bit: one-cycle pulse. A good frame has just been published.
- `crc_error` output, 1 bit: one-cycle pulse. A frame was discarded because its CRC mismatched.
- `len_error` output, 1 bit: one-cycle pulse. A frame was discarded because its length byte exceeded `MAX_LEN`.
- `timeout` output, 1 bit: one-cycle pulse. A frame was aborted by the inter-byte timeout.
- `busy` output, 1 bit: high from acceptance of 0xD5 until the frame ends for any reason.
- `payload_len` output, 8 bits: length of the last good frame.
- `buf0`…`buf15` output, 8 bits each: payload of the last good frame. Bytes at index ≥ `payload_len` are 0x00.

## Operation
- **States.** S_HUNT, S_LEN, S_DATA, S_CRC. Any illegal state returns to S_HUNT.
- **S_HUNT.** An `rx_valid` byte equal to 0xD5 moves to S_LEN, sets `busy`, and clears the working buffer and running CRC. Other bytes are ignored.
- **S_LEN.** On a byte:
  - Value > `MAX_LEN`: pulse `len_error`, go to S_HUNT.
  - Value 0: latch it as the working length, go to S_CRC.
  - Otherwise: latch it as the working length, clear the byte counter, go to S_DATA.
- **S_DATA.** Each byte:
  - is stored at working[byte_cnt];
  - updates crc = crc8(byte, crc);
  - increments byte_cnt.
  
  After the byte whose index is len−1 is stored, go to S_CRC.
- **S_CRC.** On a byte:
  - If it equals the running CRC: copy the working buffer and length to `buf*`/`payload_len` in a single clock, pulse `packet_valid`.
  - Otherwise: pulse `crc_error`; published outputs are unchanged.
  
  Either way, go to S_HUNT and clear `busy`.
- **CRC.** CRC-8 Dallas/Maxim: polynomial x^8+x^5+x^4+1, reflected, initial value 0x00, no final XOR. It covers payload bytes only. The length and start bytes are excluded.
- **Working buffer.** Separate from the published buffer. Published outputs never show a partial frame.
- **Timeout.** An idle counter resets on every `rx_valid`. In any state other than S_HUNT, reaching `TIMEOUT_CYCLES` pulses `timeout` and returns to S_HUNT.
- **0xD5 inside a frame.** It is treated as ordinary data, length, or CRC. There is no resynchronisation mid-frame.
- **Reset.** `rst` at any time, including mid-frame, forces S_HUNT and applies the reset values below.

## Timing
- **Reset values.**
  - `packet_valid`, `crc_error`, `len_error`, `timeout`, `busy` = 0.
  - `payload_len` = 0x00; all `buf*` = 0x00.
  - Internal: crc = 0, byte_cnt = 0, idle counter = 0.
- **Latency.** If the CRC byte's `rx_valid` is high in cycle N, then in cycle N+1:
  - `packet_valid` (or `crc_error`) is high;
  - the new `buf*`/`payload_len` are visible;
  - `busy` is 0.
- **Length error.** If the length byte arrives in cycle N, `len_error` is high in cycle N+1.
- **Back-to-back bytes.** `rx_valid` may be high on consecutive cycles. Every byte is consumed; there is no backpressure.
- **New start during a pulse.** A 0xD5 in cycle N+1, the same cycle a result pulse is high, starts a new frame.
- **Output stability.** Published outputs hold until the next good frame. A downstream consumer may sample them on `packet_valid` or any time after.
- **Timeout edge.** `timeout` pulses exactly `TIMEOUT_CYCLES` cycles after the last byte. If `rx_valid` arrives in that same cycle, the abort wins and the byte is evaluated in S_HUNT.

## Structure
- **Shared package** `s3g_pkg`, used by this block and the transmitter:
  - constant `S3G_START` = 8'hD5;
  - constant `S3G_MAX_LEN` = 15;
  - function `crc8_maxim(data, crc)`;
  - state encoding constants.
- **Sub-module** `s3g_crc8`: a registered CRC accumulator with clear and enable. It is natural to factor out and reusable by the transmitter.
- **Top level.** The FSM, working and published buffers, and the idle counter stay in `s3g_rx`.

## Test plan
- **Good frame.** Send D5 03 01 02 03 + crc8(01 02 03). Expect `packet_valid` one cycle after the last byte, `payload_len`=3, `buf0..2`=01 02 03, `buf3..15`=00.
- **CRC reference vector.** Send D5 09 "123456789" A1. Expect `packet_valid`. Repeat with final byte A0: expect `crc_error`, outputs still hold the previous frame.
- **Zero and maximum length.** Send D5 00 00: expect `packet_valid` with `payload_len`=0. Send D5 10: expect `len_error`, return to hunt, and no state change from the following byte 0x10.
- **Noise and timeout.** Send 00 FF, then D5 02 AA, then idle `TIMEOUT_CYCLES`. Expect `timeout`, `busy` falls, outputs unchanged. A following good frame is received correctly.
- **Back-to-back and mid-frame reset.** Send two good frames with `rx_valid` high every cycle: expect two `packet_valid` pulses. Assert `rst` mid-payload: expect all outputs 0 and a clean subsequent reception.

Source files
------------

// File: rtl/s3g_pkg.sv
// Shared definitions for the S3G host-link framing: constants, FSM encoding
// and the Dallas/Maxim CRC-8 step used by both receiver and transmitter.
package s3g_pkg;

  localparam logic [7:0] S3G_START   = 8'hD5;
  localparam int         S3G_MAX_LEN = 15;

  typedef enum logic [1:0] {
    S_HUNT = 2'd0,
    S_LEN  = 2'd1,
    S_DATA = 2'd2,
    S_CRC  = 2'd3
  } s3g_state_e;

  // Reflected x^8+x^5+x^4+1 (0x8C reversed form), one byte per call.
  function automatic logic [7:0] crc8_maxim(input logic [7:0] data, input logic [7:0] crc);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 8'h8C) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/s3g_crc8.sv
// Registered CRC-8 accumulator with synchronous clear and byte enable.
module s3g_crc8
  import s3g_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [7:0] data_i,
  output logic [7:0] crc_o
);

  logic [7:0] crc_q;

  // Accumulator register; clear has priority over a byte update.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      crc_q <= 8'h00;
    end else if (en_i) begin
      crc_q <= crc8_maxim(data_i, crc_q);
    end else begin
      crc_q <= crc_q;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/s3g_rx.sv
// S3G frame receiver: hunts for 0xD5, collects length/payload/CRC and
// publishes the payload image atomically only on a CRC match.
module s3g_rx
  import s3g_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int MAX_LEN        = S3G_MAX_LEN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       packet_valid,
  output logic       crc_error,
  output logic       len_error,
  output logic       timeout,
  output logic       busy,
  output logic [7:0] payload_len,
  output logic [7:0] buf0,  output logic [7:0] buf1,  output logic [7:0] buf2,  output logic [7:0] buf3,
  output logic [7:0] buf4,  output logic [7:0] buf5,  output logic [7:0] buf6,  output logic [7:0] buf7,
  output logic [7:0] buf8,  output logic [7:0] buf9,  output logic [7:0] buf10, output logic [7:0] buf11,
  output logic [7:0] buf12, output logic [7:0] buf13, output logic [7:0] buf14, output logic [7:0] buf15
);

  localparam int            IW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);

  s3g_state_e         state_q, state_d, state_eff_s;
  logic [3:0]         len_q, len_d, cnt_q, cnt_d;
  logic [15:0][7:0]   work_q, work_d, pub_q, pub_d;
  logic [7:0]         plen_q, plen_d;
  logic [IW-1:0]      idle_q, idle_d;
  logic               pv_q, pv_d, ce_q, ce_d, le_q, le_d, to_q, to_d, busy_q, busy_d;
  logic               abort_s, crc_clr_s, crc_en_s;
  logic [7:0]         crc_s;

  s3g_crc8 u_crc (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (crc_clr_s),
    .en_i   (crc_en_s),
    .data_i (rx_data),
    .crc_o  (crc_s)
  );

  // Next-state logic; a timeout abort overrides the state before the byte is judged.
  always_comb begin
    abort_s     = (state_q != S_HUNT) && (idle_q == IDLE_LAST);
    state_eff_s = abort_s ? S_HUNT : state_q;
    state_d     = state_eff_s;
    len_d       = len_q;
    cnt_d       = cnt_q;
    work_d      = work_q;
    pub_d       = pub_q;
    plen_d      = plen_q;
    pv_d        = 1'b0;
    ce_d        = 1'b0;
    le_d        = 1'b0;
    to_d        = abort_s;
    crc_clr_s   = 1'b0;
    crc_en_s    = 1'b0;
    if (rx_valid) begin
      idle_d = '0;
    end else if (idle_q == IDLE_LAST) begin
      idle_d = idle_q;
    end else begin
      idle_d = idle_q + IW'(1);
    end
    if (rx_valid) begin
      case (state_eff_s)
        S_HUNT: begin
          if (rx_data == S3G_START) begin
            state_d   = S_LEN;
            work_d    = '0;
            crc_clr_s = 1'b1;
          end else begin
            state_d = S_HUNT;
          end
        end
        S_LEN: begin
          if (rx_data > 8'(MAX_LEN)) begin
            le_d    = 1'b1;
            state_d = S_HUNT;
          end else begin
            len_d   = rx_data[3:0];
            cnt_d   = 4'd0;
            state_d = (rx_data == 8'h00) ? S_CRC : S_DATA;
          end
        end
        S_DATA: begin
          work_d[cnt_q] = rx_data;
          crc_en_s      = 1'b1;
          cnt_d         = cnt_q + 4'd1;
          if (cnt_q == (len_q - 4'd1)) begin
            state_d = S_CRC;
          end else begin
            state_d = S_DATA;
          end
        end
        S_CRC: begin
          if (rx_data == crc_s) begin
            pub_d  = work_q;
            plen_d = {4'h0, len_q};
            pv_d   = 1'b1;
          end else begin
            ce_d = 1'b1;
          end
          state_d = S_HUNT;
        end
        default: state_d = S_HUNT;
      endcase
    end else begin
      state_d = state_eff_s;
    end
    busy_d = (state_d != S_HUNT);
  end

  // State, buffers and registered result pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_HUNT;
      len_q   <= 4'd0;
      cnt_q   <= 4'd0;
      work_q  <= '0;
      pub_q   <= '0;
      plen_q  <= 8'h00;
      idle_q  <= '0;
      pv_q    <= 1'b0;
      ce_q    <= 1'b0;
      le_q    <= 1'b0;
      to_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      pub_q   <= pub_d;
      plen_q  <= plen_d;
      idle_q  <= idle_d;
      pv_q    <= pv_d;
      ce_q    <= ce_d;
      le_q    <= le_d;
      to_q    <= to_d;
      busy_q  <= busy_d;
    end
  end

  assign packet_valid = pv_q;
  assign crc_error    = ce_q;
  assign len_error    = le_q;
  assign timeout      = to_q;
  assign busy         = busy_q;
  assign payload_len  = plen_q;
  assign buf0  = pub_q[0];  assign buf1  = pub_q[1];  assign buf2  = pub_q[2];  assign buf3  = pub_q[3];
  assign buf4  = pub_q[4];  assign buf5  = pub_q[5];  assign buf6  = pub_q[6];  assign buf7  = pub_q[7];
  assign buf8  = pub_q[8];  assign buf9  = pub_q[9];  assign buf10 = pub_q[10]; assign buf11 = pub_q[11];
  assign buf12 = pub_q[12]; assign buf13 = pub_q[13]; assign buf14 = pub_q[14]; assign buf15 = pub_q[15];

endmodule

// File: tb/tb_s3g_rx.sv
// Self-checking bench for s3g_rx: directed frames plus random byte streams
// compared cycle by cycle against a queue-based frame model.
module tb_s3g_rx;

  localparam int T = 20;

  logic       clk = 1'b0;
  logic       rst, rx_valid;
  logic [7:0] rx_data;
  logic       packet_valid, crc_error, len_error, timeout, busy;
  logic [7:0] payload_len;
  logic [7:0] buf0, buf1, buf2, buf3, buf4, buf5, buf6, buf7;
  logic [7:0] buf8, buf9, buf10, buf11, buf12, buf13, buf14, buf15;
  logic [127:0] dut_img;

  always #5 clk = ~clk;

  s3g_rx #(.TIMEOUT_CYCLES(T), .MAX_LEN(15)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .packet_valid(packet_valid), .crc_error(crc_error), .len_error(len_error),
    .timeout(timeout), .busy(busy), .payload_len(payload_len),
    .buf0(buf0), .buf1(buf1), .buf2(buf2), .buf3(buf3), .buf4(buf4), .buf5(buf5),
    .buf6(buf6), .buf7(buf7), .buf8(buf8), .buf9(buf9), .buf10(buf10), .buf11(buf11),
    .buf12(buf12), .buf13(buf13), .buf14(buf14), .buf15(buf15)
  );

  assign dut_img = {buf15, buf14, buf13, buf12, buf11, buf10, buf9, buf8,
                    buf7, buf6, buf5, buf4, buf3, buf2, buf1, buf0};

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int pv_seen = 0;
  int to_seen = 0;

  // reference model state: bytes of the current frame after the start byte
  logic [7:0]   frame[$];
  bit           m_in;
  int           m_last;
  logic         m_pv, m_ce, m_le, m_to;
  logic [7:0]   m_len;
  logic [127:0] m_img;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [7:0] crc8_bytes(input logic [7:0] q[$], input int from, input int n);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int k = 0; k < n; k++) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ q[from + k][b];
        c  = {1'b0, c[7:1]};
        if (fb) c = c ^ 8'h8C;
      end
    end
    return c;
  endfunction

  task automatic model_step(input logic r, input logic v, input logic [7:0] d);
    int len;
    m_pv = 1'b0; m_ce = 1'b0; m_le = 1'b0; m_to = 1'b0;
    if (r) begin
      m_in = 1'b0; frame.delete(); m_len = 8'h00; m_img = '0;
    end else begin
      if (m_in && (cyc - m_last >= T)) begin
        m_to = 1'b1;
        m_in = 1'b0;
      end
      if (v) begin
        m_last = cyc;
        if (!m_in) begin
          if (d == 8'hD5) begin
            m_in = 1'b1;
            frame.delete();
          end
        end else begin
          frame.push_back(d);
          len = int'(frame[0]);
          if (frame.size() == 1 && len > 15) begin
            m_le = 1'b1;
            m_in = 1'b0;
          end else if (frame.size() == len + 2) begin
            if (d == crc8_bytes(frame, 1, len)) begin
              m_pv  = 1'b1;
              m_len = frame[0];
              m_img = '0;
              for (int i = 0; i < len; i++) m_img[i*8 +: 8] = frame[i+1];
            end else begin
              m_ce = 1'b1;
            end
            m_in = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic tick(input logic r, input logic v, input logic [7:0] d);
    rst = r; rx_valid = v; rx_data = d;
    model_step(r, v, d);
    @(posedge clk);
    #1;
    check_val("flags", {packet_valid, crc_error, len_error, timeout, busy},
              {m_pv, m_ce, m_le, m_to, m_in});
    check_val("plen", payload_len, m_len);
    check_val("bufs", dut_img, m_img);
    if (packet_valid) pv_seen++;
    if (timeout) to_seen++;
    cyc++;
  endtask

  task automatic send_q(input logic [7:0] q[$]);
    foreach (q[i]) tick(1'b0, 1'b1, q[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0, 8'h00);
  endtask

  logic [7:0] q[$];
  logic [7:0] p[$];
  int         len, gap, sel;

  initial begin
    m_in = 1'b0; m_last = 0; m_len = 8'h00; m_img = '0;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) tick(1'b1, 1'b0, 8'h00);
    check_val("reset_img", dut_img, 128'h0);

    // good frame 01 02 03
    p = '{8'h01, 8'h02, 8'h03};
    q = '{8'hD5, 8'h03, 8'h01, 8'h02, 8'h03};
    q.push_back(crc8_bytes(p, 0, 3));
    send_q(q);
    check_val("good_pv", packet_valid, 1'b1);
    check_val("good_len", payload_len, 8'd3);
    check_val("good_buf", dut_img, 128'h030201);

    // check-value vector "123456789" -> A1, then A0 is rejected
    q = '{8'hD5, 8'h09, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hA1};
    send_q(q);
    check_val("ref_pv", packet_valid, 1'b1);
    q[11] = 8'hA0;
    send_q(q);
    check_val("ref_crcerr", crc_error, 1'b1);
    check_val("ref_hold_len", payload_len, 8'd9);

    // zero length, then oversize length followed by a stray 0x10
    send_q('{8'hD5, 8'h00, 8'h00});
    check_val("zero_pv", packet_valid, 1'b1);
    check_val("zero_len", payload_len, 8'd0);
    send_q('{8'hD5, 8'h10});
    check_val("len_err", len_error, 1'b1);
    send_q('{8'h10});
    check_val("len_hunt", busy, 1'b0);

    // noise then truncated frame left to time out
    send_q('{8'h00, 8'hFF, 8'hD5, 8'h02, 8'hAA});
    to_seen = 0;
    idle(T + 3);
    check_val("to_seen", to_seen, 1);
    check_val("to_busy", busy, 1'b0);
    send_q('{8'hD5, 8'h01, 8'h5A, crc8_bytes('{8'h5A}, 0, 1)});
    check_val("after_to_pv", packet_valid, 1'b1);

    // two good frames with rx_valid high every cycle
    pv_seen = 0;
    q = '{8'hD5, 8'h02, 8'hD5, 8'h11};
    q.push_back(crc8_bytes('{8'hD5, 8'h11}, 0, 2));
    q.push_back(8'hD5); q.push_back(8'h01); q.push_back(8'h77);
    q.push_back(crc8_bytes('{8'h77}, 0, 1));
    send_q(q);
    idle(1);
    check_val("b2b_pv", pv_seen, 2);

    // reset in the middle of a payload
    send_q('{8'hD5, 8'h05, 8'h11, 8'h22});
    tick(1'b1, 1'b0, 8'h00);
    check_val("rst_img", dut_img, 128'h0);
    check_val("rst_len", payload_len, 8'd0);
    send_q('{8'hD5, 8'h01, 8'h33, crc8_bytes('{8'h33}, 0, 1)});
    check_val("rst_after_pv", packet_valid, 1'b1);

    // random traffic: good/bad frames, noise, gaps around the timeout edge
    for (int f = 0; f < 300; f++) begin
      q.delete(); p.delete();
      if ($urandom_range(0, 7) == 0) q.push_back(8'($urandom));
      q.push_back(8'hD5);
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(16, 255) : $urandom_range(0, 15);
      q.push_back(8'(len));
      if (len <= 15) begin
        for (int i = 0; i < len; i++) p.push_back(($urandom_range(0, 9) == 0) ? 8'hD5 : 8'($urandom));
        foreach (p[i]) q.push_back(p[i]);
        q.push_back(crc8_bytes(p, 0, len) ^ (($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00));
        if ($urandom_range(0, 14) == 0) void'(q.pop_back());
      end
      foreach (q[i]) begin
        sel = $urandom_range(0, 59);
        if (sel < 45)      gap = 0;
        else if (sel < 57) gap = $urandom_range(1, 3);
        else               gap = T - 2 + $urandom_range(0, 3);
        idle(gap);
        if ($urandom_range(0, 999) == 0) tick(1'b1, 1'b0, 8'h00);
        tick(1'b0, 1'b1, q[i]);
      end
      idle($urandom_range(0, 2));
    end
    idle(T + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
